// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter: merges multiplier results into the register-file write port behind the main pipeline.
// Optional macro MUL_WB_BYPASS_EN lets a lone multiplier result skip the FIFO when it is empty.

module mul_wb_arbiter_chk #(
  parameter int CNT_W = 2,
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  input logic             i_push,
  input logic [CNT_W-1:0] i_count
);
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(i_push && (i_count == CNT_W'(DEPTH))));
endmodule

module mul_wb_arbiter #(
  parameter int ARCH_LEN  = 32,
  parameter int REG_IDX_W = 5,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kill,
  input  logic                 mul_valid,
  input  logic [REG_IDX_W-1:0] mul_rd,
  input  logic [ARCH_LEN-1:0]  mul_data,
  output logic                 stall_mul,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [ARCH_LEN-1:0]  alu_data,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [ARCH_LEN-1:0]  wb_data,
  output logic                 wb_from_mul
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_IDX_W-1:0] r_mem_rd   [DEPTH];
  logic [ARCH_LEN-1:0]  r_mem_data [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_wb_valid;
  logic [REG_IDX_W-1:0] r_wb_rd;
  logic [ARCH_LEN-1:0]  r_wb_data;
  logic                 r_wb_from_mul;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_sel_valid;
  logic                 w_sel_mul;
  logic [REG_IDX_W-1:0] w_sel_rd;
  logic [ARCH_LEN-1:0]  w_sel_data;
  logic                 w_wb_valid_nxt;

  // Stall is a pure function of occupancy, so mul_valid never feeds it combinationally.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_accept  = mul_valid & ~w_full & ~kill;
  assign stall_mul = w_full;

  // Priority select: main pipeline, then FIFO head, then the fresh multiplier result.
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_mul   = 1'b0;
    w_sel_rd    = r_wb_rd;
    w_sel_data  = r_wb_data;
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
      w_push      = w_accept;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_sel_valid = 1'b1;
      w_sel_mul   = 1'b1;
      w_sel_rd    = r_mem_rd[r_rd_ptr];
      w_sel_data  = r_mem_data[r_rd_ptr];
      w_push      = w_accept;
    end else if (w_accept) begin
`ifdef MUL_WB_BYPASS_EN
      w_sel_valid = 1'b1;
      w_sel_mul   = 1'b1;
      w_sel_rd    = mul_rd;
      w_sel_data  = mul_data;
`else
      w_push      = 1'b1;
`endif
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // x0 writes are consumed silently; a kill only suppresses multiplier-sourced writes.
  assign w_wb_valid_nxt = w_sel_valid & (w_sel_rd != {REG_IDX_W{1'b0}}) & ~(kill & w_sel_mul);

  // Writeback output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= {REG_IDX_W{1'b0}};
      r_wb_data     <= {ARCH_LEN{1'b0}};
      r_wb_from_mul <= 1'b0;
    end else begin
      r_wb_valid    <= w_wb_valid_nxt;
      r_wb_rd       <= w_sel_rd;
      r_wb_data     <= w_sel_data;
      r_wb_from_mul <= w_sel_mul & ~kill;
    end
  end

  // FIFO pointers and occupancy; kill empties the queue in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (kill) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else        r_wr_ptr <= r_wr_ptr;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      else        r_rd_ptr <= r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= mul_rd;
      r_mem_data[r_wr_ptr] <= mul_data;
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign wb_from_mul = r_wb_from_mul;

  mul_wb_arbiter_chk #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_count (r_count)
  );
endmodule
